// File: rtl/filter2d_obuf.sv
// filter2d_obuf: show-ahead output FIFO for a 2D filter pixel stream.
// Each entry holds {eof, eol, pixel}. Line/frame tags come from col/row
// counters that advance on every strobe, so geometry stays locked even
// when pixels are dropped on overflow.
// Optional statistics (sticky overflow flag, completed-frame counter) are
// built only when FILTER2D_OBUF_STAT_EN is defined; otherwise both outputs
// are tied to zero.
module filter2d_obuf #(
    parameter int DEPTH = 16,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     i_strb,
    input  logic [7:0]               i_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [7:0]               o_data,
    output logic                     o_eol,
    output logic                     o_eof,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_ovf,
    output logic [7:0]               o_frame_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [9:0]    head;
    logic          full;
    logic          pop;
    logic          push;
    logic          last_col;
    logic          last_row;
    logic          tag_eol;
    logic          tag_eof;

    // Handshake decode, geometry tags and gated show-ahead head outputs
    always_comb begin
        full     = (level == LW'(DEPTH));
        o_valid  = (level != '0);
        pop      = o_valid && o_ready;
        push     = i_strb && (!full || pop);
        last_col = (col == CW'(IMG_W - 1));
        last_row = (row == RW'(IMG_H - 1));
        tag_eol  = last_col;
        tag_eof  = last_col && last_row;
        head     = mem[rd_ptr];
        // Gating on o_valid makes the head read zero while in reset
        o_data   = o_valid ? head[7:0] : '0;
        o_eol    = o_valid && head[8];
        o_eof    = o_valid && head[9];
        o_level  = level;
    end

    // Storage array: written on push only, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tag_eof, tag_eol, i_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Column/row position of the incoming pixel, advanced on every strobe
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            col <= '0;
            row <= '0;
        end else if (i_strb) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

`ifdef FILTER2D_OBUF_STAT_EN
    logic       ovf_q;
    logic [7:0] frame_q;
    logic       drop;

    // A strobe that could not be pushed is a dropped pixel
    always_comb begin
        drop = i_strb && !push;
    end

    // Sticky overflow flag and count of frames fully read out
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ovf_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (pop && head[9]) begin
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    // Drive statistics outputs
    always_comb begin
        o_ovf       = ovf_q;
        o_frame_cnt = frame_q;
    end
`else
    // Statistics disabled: outputs held at zero
    always_comb begin
        o_ovf       = 1'b0;
        o_frame_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_filter2d_obuf.sv
// Self-checking bench for filter2d_obuf using a queue-based reference model.
// Geometry is shrunk (16x8) so full-frame scenarios stay short.
module tb_filter2d_obuf;

    localparam int DEPTH = 16;
    localparam int W     = 16;
    localparam int H     = 8;
    localparam int FRAME = W * H;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef FILTER2D_OBUF_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          n_reset;
    logic          i_strb;
    logic [7:0]    i_data;
    logic          o_valid;
    logic          o_ready;
    logic [7:0]    o_data;
    logic          o_eol;
    logic          o_eof;
    logic [LW-1:0] o_level;
    logic          o_ovf;
    logic [7:0]    o_frame_cnt;

    filter2d_obuf #(.DEPTH(DEPTH), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_strb     (i_strb),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_eol      (o_eol),
        .o_eof      (o_eof),
        .o_level    (o_level),
        .o_ovf      (o_ovf),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         eol;
        bit         eof;
    } ent_t;

    ent_t        mq[$];
    int unsigned pix_idx;
    bit          m_ovf;
    int unsigned m_fcnt;
    logic [7:0]  in_log[$];
    logic [7:0]  out_log[$];
    bit          log_en;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        pix_idx = 0;
        m_ovf   = 1'b0;
        m_fcnt  = 0;
    endfunction

    // One clock edge of the reference: pop then push, tags by pixel index
    function automatic void model_edge(input bit s, input logic [7:0] d, input bit r);
        bit   do_pop;
        bit   do_push;
        ent_t e;
        ent_t h;
        do_pop  = (mq.size() != 0) && r;
        do_push = s && ((mq.size() < DEPTH) || do_pop);
        e.d   = d;
        e.eol = ((pix_idx % W) == W - 1);
        e.eof = (pix_idx == FRAME - 1);
        if (s) pix_idx = (pix_idx + 1) % FRAME;
        if (do_pop) begin
            h = mq.pop_front();
            if (h.eof) m_fcnt = (m_fcnt + 1) % 256;
        end
        if (do_push) mq.push_back(e);
        else if (s) m_ovf = 1'b1;
    endfunction

    task automatic check_all();
        chk("valid", 32'(o_valid), 32'(mq.size() != 0));
        chk("level", 32'(o_level), 32'(mq.size()));
        if (mq.size() != 0) begin
            chk("data", 32'(o_data), 32'(mq[0].d));
            chk("eol", 32'(o_eol), 32'(mq[0].eol));
            chk("eof", 32'(o_eof), 32'(mq[0].eof));
        end
        chk("ovf", 32'(o_ovf), STAT ? 32'(m_ovf) : 32'd0);
        chk("frame_cnt", 32'(o_frame_cnt), STAT ? 32'(m_fcnt) : 32'd0);
    endtask

    task automatic step(input bit s, input logic [7:0] d, input bit r);
        i_strb  = s;
        i_data  = d;
        o_ready = r;
        if (log_en && o_valid && r) out_log.push_back(o_data);
        if (log_en && s) in_log.push_back(d);
        @(posedge clk);
        model_edge(s, d, r);
        #1;
        check_all();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        n_reset = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_eol", 32'(o_eol), 32'd0);
        chk("rst_eof", 32'(o_eof), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        int guard;
        n_tests = 0;
        n_fail  = 0;
        log_en  = 1'b0;
        n_reset = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;
        model_reset();

        // Reset state
        hard_reset();

        // Single pixel through an idle FIFO
        step(1'b1, 8'h5A, 1'b1);
        chk("single_valid", 32'(o_valid), 32'd1);
        chk("single_data", 32'(o_data), 32'h5A);
        chk("single_level", 32'(o_level), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("single_drain", 32'(o_level), 32'd0);

        // Fill to DEPTH, then overflow strobe is dropped
        hard_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        chk("ovf_level", 32'(o_level), 32'(DEPTH));
        chk("ovf_flag", 32'(o_ovf), STAT ? 32'd1 : 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_readout", 32'(o_data), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        chk("ovf_empty", 32'(o_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        hard_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("full_level", 32'(o_level), 32'(DEPTH));
        step(1'b1, 8'hAA, 1'b1);
        chk("pp_level", 32'(o_level), 32'(DEPTH));
        chk("pp_ovf", 32'(o_ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("pp_readout", 32'(o_data), (i < DEPTH - 1) ? 32'(8'h11 + i) : 32'hAA);
            step(1'b0, 8'h00, 1'b1);
        end

        // Full frame stream, consumer always ready
        hard_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            chk("frame_eol", 32'(o_eol), 32'((i % W) == W - 1));
            chk("frame_eof", 32'(o_eof), 32'(i == FRAME - 1));
        end
        step(1'b0, 8'h00, 1'b1);
        chk("frame_cnt1", 32'(o_frame_cnt), STAT ? 32'd1 : 32'd0);

        // Three frames, sparse strobes, consumer ready about half the time
        hard_reset();
        in_log.delete();
        out_log.delete();
        log_en = 1'b1;
        for (int c = 0; c < 3 * FRAME * 17; c++)
            step((c % 17) == 0, 8'($urandom), 1'($urandom));
        guard = 0;
        while (o_valid && guard < 4 * DEPTH) begin
            step(1'b0, 8'h00, 1'b1);
            guard++;
        end
        log_en = 1'b0;
        chk("drain_bound", 32'(o_valid), 32'd0);
        chk("seq_len", 32'(out_log.size()), 32'(in_log.size()));
        for (int i = 0; i < in_log.size() && i < out_log.size(); i++)
            chk("seq_data", 32'(out_log[i]), 32'(in_log[i]));
        chk("seq_ovf", 32'(o_ovf), 32'd0);
        chk("frame_cnt3", 32'(o_frame_cnt), STAT ? 32'd3 : 32'd0);

        // Asynchronous reset mid-frame, then geometry restarts at col 0/row 0
        hard_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'($urandom));
        #2;
        n_reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_level", 32'(o_level), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_ovf", 32'(o_ovf), 32'd0);
        chk("mid_rst_fcnt", 32'(o_frame_cnt), 32'd0);
        #2;
        n_reset = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            chk("post_rst_eol", 32'(o_eol), 32'((i % W) == W - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
